// File: rtl/frame_min_max_pkg.sv
// Shared types and constants for the frame_min_max streaming reducer.
package frame_min_max_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // A frame length of zero is treated as a single-sample frame.
  localparam int unsigned FRAME_LEN_ZERO_SUB = 1;

endpackage

// File: rtl/comparator_lt.sv
// Two's-complement signed less-than: lt = (a < b).
module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  assign lt = ($signed(a) < $signed(b));

endmodule

// File: rtl/frame_min_max.sv
// Streaming signed min/max reducer over frames of frame_len samples, valid/ready on both sides.
// Define FRAME_MIN_MAX_INDEX_EN to add out_min_idx/out_max_idx (zero-based extremum positions).
module frame_min_max
  import frame_min_max_pkg::*;
#(
  parameter int N     = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_min,
`ifdef FRAME_MIN_MAX_INDEX_EN
  output logic [LEN_W-1:0] out_min_idx,
  output logic [LEN_W-1:0] out_max_idx,
`endif
  output logic [N-1:0]     out_max
);

  state_t           state, state_next;
  logic [N-1:0]     min_q, max_q;
  logic [LEN_W-1:0] count, count_inc, len_q, len_eff;
  logic             accept, in_lt_min, max_lt_in;

  comparator_lt #(.N(N)) u_min_lt (.a(in_data), .b(min_q),   .lt(in_lt_min));
  comparator_lt #(.N(N)) u_max_lt (.a(max_q),   .b(in_data), .lt(max_lt_in));

  assign accept    = in_valid && in_ready;
  assign len_eff   = (frame_len == '0) ? LEN_W'(FRAME_LEN_ZERO_SUB) : frame_len;
  assign count_inc = count + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = (len_eff == LEN_W'(1)) ? S_HOLD : S_ACCUM;
      S_ACCUM: if (accept && (count_inc == len_q)) state_next = S_HOLD;
      S_HOLD:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      min_q    <= '0;
      max_q    <= '0;
      count    <= '0;
      len_q    <= '0;
    end else begin
      state <= state_next;
      // Registered from next state so HOLD never sees a ready upstream.
      in_ready <= (state_next != S_HOLD);
      if (accept) begin
        if (state == S_IDLE) begin
          min_q <= in_data;
          max_q <= in_data;
          len_q <= len_eff;
          count <= LEN_W'(1);
        end else begin
          if (in_lt_min) min_q <= in_data;
          if (max_lt_in) max_q <= in_data;
          count <= count_inc;
        end
      end
    end
  end

`ifdef FRAME_MIN_MAX_INDEX_EN
  // count holds the zero-based index of the sample being accepted in S_ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_min_idx <= '0;
      out_max_idx <= '0;
    end else if (accept) begin
      if (state == S_IDLE) begin
        out_min_idx <= '0;
        out_max_idx <= '0;
      end else begin
        if (in_lt_min) out_min_idx <= count;
        if (max_lt_in) out_max_idx <= count;
      end
    end
  end
`endif

  assign out_valid = (state == S_HOLD);
  assign out_min   = min_q;
  assign out_max   = max_q;

endmodule

// File: tb/tb_frame_min_max.sv
// Directed self-checking bench for frame_min_max (index checks when FRAME_MIN_MAX_INDEX_EN is defined).
module tb_frame_min_max;

  localparam int N     = 32;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_min;
  logic [N-1:0]     out_max;
`ifdef FRAME_MIN_MAX_INDEX_EN
  logic [LEN_W-1:0] out_min_idx;
  logic [LEN_W-1:0] out_max_idx;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_min_max #(.N(N), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_len (frame_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
`ifdef FRAME_MIN_MAX_INDEX_EN
    .out_min_idx (out_min_idx),
    .out_max_idx (out_max_idx),
`endif
    .out_max   (out_max)
  );

  // Drives one sample and returns #1 after the edge that accepted it; bounded wait.
  task automatic send_sample(input logic [N-1:0] d);
    logic rdy;
    bit   done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      done = rdy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: sample %0h not accepted within 20 cycles, required acceptance", d);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_min !== '0 || out_max !== '0) begin errors++; $display("FAIL reset_minmax: got %h/%h required 0/0", out_min, out_max); end
`ifdef FRAME_MIN_MAX_INDEX_EN
    checks++; if (out_min_idx !== '0 || out_max_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d/%0d required 0/0", out_min_idx, out_max_idx); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    frame_len = 8'd4;
    send_sample(32'd5);
    send_sample(-32'sd3);
    send_sample(32'd7);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b required 0", out_valid); end
    send_sample(-32'sd3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b required 1", out_valid); end
    checks++; if (out_min !== -32'sd3) begin errors++; $display("FAIL basic_min: got %0d required -3", $signed(out_min)); end
    checks++; if (out_max !== 32'd7) begin errors++; $display("FAIL basic_max: got %0d required 7", $signed(out_max)); end
`ifdef FRAME_MIN_MAX_INDEX_EN
    checks++; if (out_min_idx !== 8'd1 || out_max_idx !== 8'd2) begin errors++; $display("FAIL basic_idx: got %0d/%0d required 1/2", out_min_idx, out_max_idx); end
`endif
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release: valid/ready got %b/%b required 0/1", out_valid, in_ready); end
  endtask

  task automatic test_signed_extremes();
    frame_len = 8'd3;
    send_sample(32'h8000_0000);
    send_sample(32'h7FFF_FFFF);
    send_sample(32'h0000_0000);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL extremes_valid: got %b required 1", out_valid); end
    checks++; if (out_min !== 32'h8000_0000) begin errors++; $display("FAIL extremes_min: got %h required 80000000", out_min); end
    checks++; if (out_max !== 32'h7FFF_FFFF) begin errors++; $display("FAIL extremes_max: got %h required 7fffffff", out_max); end
`ifdef FRAME_MIN_MAX_INDEX_EN
    checks++; if (out_min_idx !== 8'd0 || out_max_idx !== 8'd1) begin errors++; $display("FAIL extremes_idx: got %0d/%0d required 0/1", out_min_idx, out_max_idx); end
`endif
    handshake();
  endtask

  task automatic test_len_zero();
    frame_len = 8'd0;
    send_sample(32'd42);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len0_valid: got %b required 1", out_valid); end
    checks++; if (out_min !== 32'd42 || out_max !== 32'd42) begin errors++; $display("FAIL len0_minmax: got %0d/%0d required 42/42", out_min, out_max); end
    handshake();
  endtask

  task automatic test_stall_hold();
    frame_len = 8'd3;
    send_sample(32'd3);
    in_data = 32'd1000;
    @(posedge clk); #1;
    send_sample(-32'sd8);
    in_data = 32'd1000;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_early_valid: got %b required 0", out_valid); end
    frame_len = 8'd1;
    send_sample(32'd6);
    // Upstream keeps offering a bogus sample while the result is held.
    in_valid = 1'b1;
    in_data  = 32'd999;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_min !== -32'sd8 || out_max !== 32'd6) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ready/valid/min/max got %b/%b/%0d/%0d required 0/1/-8/6",
                 i, in_ready, out_valid, $signed(out_min), $signed(out_max));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    handshake();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b required 0", out_valid); end
  endtask

  task automatic test_reset_mid_frame();
    frame_len = 8'd4;
    send_sample(32'd100);
    send_sample(-32'sd100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_min !== '0 || out_max !== '0) begin errors++; $display("FAIL midreset_clear: valid/min/max got %b/%0d/%0d required 0/0/0", out_valid, $signed(out_min), $signed(out_max)); end
    send_sample(32'd9);
    send_sample(32'd1);
    send_sample(32'd4);
    send_sample(32'd2);
    checks++; if (out_valid !== 1'b1 || out_min !== 32'd1 || out_max !== 32'd9) begin errors++; $display("FAIL midreset_result: valid/min/max got %b/%0d/%0d required 1/1/9", out_valid, $signed(out_min), $signed(out_max)); end
`ifdef FRAME_MIN_MAX_INDEX_EN
    checks++; if (out_min_idx !== 8'd1 || out_max_idx !== 8'd0) begin errors++; $display("FAIL midreset_idx: got %0d/%0d required 1/0", out_min_idx, out_max_idx); end
`endif
    // Reset while holding a result drops out_valid on the next cycle.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_min !== '0) begin errors++; $display("FAIL holdreset: valid/min got %b/%0d required 0/0", out_valid, $signed(out_min)); end
  endtask

  task automatic test_back_to_back();
    frame_len = 8'd2;
    send_sample(32'd10);
    frame_len = 8'd5;
    send_sample(32'd20);
    checks++; if (out_valid !== 1'b1 || out_min !== 32'd10 || out_max !== 32'd20) begin errors++; $display("FAIL b2b_first: valid/min/max got %b/%0d/%0d required 1/10/20", out_valid, $signed(out_min), $signed(out_max)); end
    handshake();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_handshake: got %b required 1", in_ready); end
    send_sample(-32'sd1);
    send_sample(-32'sd2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_len5_early: got %b required 0", out_valid); end
    send_sample(32'd0);
    send_sample(-32'sd2);
    send_sample(32'd50);
    checks++; if (out_valid !== 1'b1 || out_min !== -32'sd2 || out_max !== 32'd50) begin errors++; $display("FAIL b2b_second: valid/min/max got %b/%0d/%0d required 1/-2/50", out_valid, $signed(out_min), $signed(out_max)); end
`ifdef FRAME_MIN_MAX_INDEX_EN
    checks++; if (out_min_idx !== 8'd1 || out_max_idx !== 8'd4) begin errors++; $display("FAIL b2b_idx: got %0d/%0d required 1/4", out_min_idx, out_max_idx); end
`endif
    handshake();
  endtask

  initial begin
    rst       = 1'b1;
    frame_len = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_signed_extremes();
    test_len_zero();
    test_stall_hold();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
